// File: rtl/vga_sync_decoder_if.sv
// Sync-in / timing-out bundle between a VGA sync source and the sync decoder.
// The source drives hsync/vsync; the decoder returns coordinates and lock status.
interface vga_sync_decoder_if;
    logic        hsync;
    logic        vsync;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        de;
    logic        locked;
    logic        frame_start;
    logic        sync_err;
    logic [7:0]  err_count;

    modport master (
        output hsync,
        output vsync,
        input  pixel_x,
        input  pixel_y,
        input  de,
        input  locked,
        input  frame_start,
        input  sync_err,
        input  err_count
    );

    modport slave (
        input  hsync,
        input  vsync,
        output pixel_x,
        output pixel_y,
        output de,
        output locked,
        output frame_start,
        output sync_err,
        output err_count
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Sync-only VGA receiver: rebuilds pixel coordinates and display enable from
// active-low hsync/vsync, and tracks line/frame timing to declare lock.
module vga_sync_decoder #(
    parameter int HD          = 640,
    parameter int HR          = 16,
    parameter int HRET        = 96,
    parameter int HL          = 48,
    parameter int VD          = 480,
    parameter int VB          = 10,
    parameter int VRET        = 2,
    parameter int VT          = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    vga_sync_decoder_if.slave bus
);

    localparam int HTOT = HD + HR + HRET + HL;
    localparam int VTOT = VD + VB + VRET + VT;
    localparam int GW   = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [11:0]   X_LAST    = 12'(HTOT - 1);
    localparam logic [11:0]   Y_LAST    = 12'(VTOT - 1);
    localparam logic [11:0]   X_HS_FALL = 12'(HD + HR);
    localparam logic [11:0]   X_HS_RISE = 12'(HD + HR + HRET);
    localparam logic [11:0]   Y_VS_FALL = 12'(VD + VB);
    localparam logic [11:0]   X_DE_END  = 12'(HD);
    localparam logic [11:0]   Y_DE_END  = 12'(VD);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state, state_next;
    logic        h_seen, h_seen_next;
    logic [GW-1:0] good, good_next;

    logic        hs_prev, vs_prev;
    logic        hfall, hrise, vfall;
    logic [11:0] x, y;
    logic [11:0] x_pred, y_pred, x_next, y_next;
    logic        pred_hfall, pred_vfall, violation;

    logic        de_r, locked_r, frame_start_r, sync_err_r;
    logic [7:0]  err_cnt;

    always_comb begin
        hfall = ~bus.hsync & hs_prev;
        hrise = bus.hsync & ~hs_prev;
        vfall = ~bus.vsync & vs_prev;
    end

    // Free-running position of the incoming sample; received edges override it.
    always_comb begin
        x_pred = (x == X_LAST) ? 12'd0 : x + 12'd1;
        y_pred = y;
        if (x == X_LAST) begin
            y_pred = (y == Y_LAST) ? 12'd0 : y + 12'd1;
        end
        x_next = hfall ? X_HS_FALL : x_pred;
        y_next = vfall ? Y_VS_FALL : y_pred;
    end

    always_comb begin
        pred_hfall  = (x_pred == X_HS_FALL);
        pred_vfall  = (x_pred == 12'd0) && (y_pred == Y_VS_FALL);
        violation   = (state != SEARCH) &&
                      ((hfall != pred_hfall) ||
                       (hrise && (x_pred != X_HS_RISE)) ||
                       (vfall != pred_vfall));
        state_next  = state;
        h_seen_next = h_seen;
        good_next   = good;
        case (state)
            SEARCH: begin
                if (hfall) begin
                    h_seen_next = 1'b1;
                end
                if (vfall && (h_seen || hfall)) begin
                    good_next  = '0;
                    state_next = VERIFY;
                end
            end
            VERIFY: begin
                if (violation) begin
                    h_seen_next = 1'b0;
                    state_next  = SEARCH;
                end else if (vfall) begin
                    good_next = good + GW'(1);
                    if (good_next == GOOD_LOCK) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (violation) begin
                    h_seen_next = 1'b0;
                    state_next  = SEARCH;
                end
            end
            default: begin
                h_seen_next = 1'b0;
                state_next  = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SEARCH;
            h_seen <= 1'b0;
            good   <= '0;
        end else begin
            state  <= state_next;
            h_seen <= h_seen_next;
            good   <= good_next;
        end
    end

    // de and frame_start are gated by the lock status in force before this sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            x             <= 12'd0;
            y             <= 12'd0;
            hs_prev       <= 1'b1;
            vs_prev       <= 1'b1;
            de_r          <= 1'b0;
            locked_r      <= 1'b0;
            frame_start_r <= 1'b0;
            sync_err_r    <= 1'b0;
            err_cnt       <= 8'd0;
        end else begin
            x             <= x_next;
            y             <= y_next;
            hs_prev       <= bus.hsync;
            vs_prev       <= bus.vsync;
            de_r          <= locked_r && (x_next < X_DE_END) && (y_next < Y_DE_END);
            frame_start_r <= locked_r && (x_next == 12'd0) && (y_next == 12'd0);
            locked_r      <= (state_next == LOCKED);
            sync_err_r    <= violation;
            if (violation && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign bus.pixel_x     = x;
    assign bus.pixel_y     = y;
    assign bus.de          = de_r;
    assign bus.locked      = locked_r;
    assign bus.frame_start = frame_start_r;
    assign bus.sync_err    = sync_err_r;
    assign bus.err_count   = err_cnt;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a shrunken 16x9 timing: a reference sync
// generator feeds the decoder and a queue of expected outputs is compared each cycle.
module tb_vga_sync_decoder;

    localparam int T_HD    = 8;
    localparam int T_HR    = 2;
    localparam int T_HRET  = 3;
    localparam int T_HL    = 3;
    localparam int T_VD    = 4;
    localparam int T_VB    = 2;
    localparam int T_VRET  = 1;
    localparam int T_VT    = 2;
    localparam int T_LOCK  = 2;
    localparam int T_HTOT  = T_HD + T_HR + T_HRET + T_HL;
    localparam int T_VTOT  = T_VD + T_VB + T_VRET + T_VT;
    localparam int FRAME   = T_HTOT * T_VTOT;
    localparam int HS_FALL = T_HD + T_HR;
    localparam int HS_RISE = HS_FALL + T_HRET;
    localparam int VS_LINE = T_VD + T_VB;

    typedef struct {
        logic        hsync;
        logic        vsync;
        logic [11:0] x;
        logic [11:0] y;
        logic        de;
        logic        frame_start;
        logic        sync_err;
        logic        locked;
        logic [7:0]  err_count;
        logic        chk_pos;
        logic        chk_flags;
    } vec_t;

    logic clk;
    logic rst;
    vga_sync_decoder_if bus ();

    vga_sync_decoder #(
        .HD(T_HD), .HR(T_HR), .HRET(T_HRET), .HL(T_HL),
        .VD(T_VD), .VB(T_VB), .VRET(T_VRET), .VT(T_VT),
        .LOCK_FRAMES(T_LOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    vec_t exp_q[$];
    vec_t table_vecs[10];
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   gx, gy, gen_vt, gen_frame, vf_left, exp_err;
    logic lk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic vec_t mk(input logic hs, input logic vs, input int xv, input int yv,
                                input logic se, input int ec);
        vec_t v;
        v.hsync       = hs;
        v.vsync       = vs;
        v.x           = 12'(xv);
        v.y           = 12'(yv);
        v.de          = 1'b0;
        v.frame_start = 1'b0;
        v.sync_err    = se;
        v.locked      = 1'b0;
        v.err_count   = 8'(ec);
        v.chk_pos     = 1'b1;
        v.chk_flags   = 1'b1;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.hsync = v.hsync;
        bus.vsync = v.vsync;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL scoreboard @cycle %0d: got empty queue, expected an entry", cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.chk_pos) begin
            check_val("pixel_x", int'(bus.pixel_x), int'(e.x));
            check_val("pixel_y", int'(bus.pixel_y), int'(e.y));
        end
        if (e.chk_flags) begin
            check_val("de", int'(bus.de), int'(e.de));
            check_val("frame_start", int'(bus.frame_start), int'(e.frame_start));
            check_val("sync_err", int'(bus.sync_err), int'(e.sync_err));
            check_val("locked", int'(bus.locked), int'(e.locked));
            check_val("err_count", int'(bus.err_count), int'(e.err_count));
        end
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pixel_x", int'(bus.pixel_x), 0);
        check_val("rst_pixel_y", int'(bus.pixel_y), 0);
        check_val("rst_de", int'(bus.de), 0);
        check_val("rst_locked", int'(bus.locked), 0);
        check_val("rst_frame_start", int'(bus.frame_start), 0);
        check_val("rst_sync_err", int'(bus.sync_err), 0);
        check_val("rst_err_count", int'(bus.err_count), 0);
        rst       = 1'b0;
        gx        = 0;
        gy        = 0;
        gen_frame = 0;
        lk        = 1'b0;
        vf_left   = T_LOCK + 1;
        exp_err   = 0;
        exp_q.delete();
    endtask

    function automatic logic gen_hs();
        return !((gx >= HS_FALL) && (gx < HS_RISE));
    endfunction

    function automatic logic gen_vs();
        return !((gy >= VS_LINE) && (gy < VS_LINE + T_VRET));
    endfunction

    // Expected decoder response to the current generator sample; tracks lock and error count.
    task automatic gen_vec(output vec_t v, input logic err_here, input logic pos_known);
        logic lk_new;
        v.hsync       = gen_hs();
        v.vsync       = gen_vs();
        v.x           = 12'(gx);
        v.y           = 12'(gy);
        v.de          = lk && (gx < T_HD) && (gy < T_VD);
        v.frame_start = lk && (gx == 0) && (gy == 0);
        lk_new        = lk;
        if (err_here) begin
            lk_new  = 1'b0;
            vf_left = T_LOCK + 1;
            if (exp_err < 255) exp_err++;
        end else if ((gx == 0) && (gy == VS_LINE) && (vf_left > 0)) begin
            vf_left--;
            if (vf_left == 0) lk_new = 1'b1;
        end
        v.sync_err  = err_here;
        v.locked    = lk_new;
        v.err_count = 8'(exp_err);
        v.chk_pos   = pos_known;
        v.chk_flags = 1'b1;
        lk          = lk_new;
    endtask

    task automatic gen_advance();
        gx++;
        if (gx == T_HTOT) begin
            gx = 0;
            gy++;
            if (gy == T_VD + T_VB + T_VRET + gen_vt) begin
                gy = 0;
                gen_frame++;
            end
        end
    endtask

    task automatic run_sample(input vec_t v);
        applyStimulus(v);
        checkOutput();
        gen_advance();
    endtask

    task automatic gen_step(input logic err_here, input logic pos_known);
        vec_t v;
        gen_vec(v, err_here, pos_known);
        run_sample(v);
    endtask

    initial begin
        vec_t v;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        gen_vt    = T_VT;

        // Directed edges from reset: realignment in SEARCH, entry to VERIFY, early hfall.
        table_vecs[0] = mk(1'b1, 1'b1, 1,  0, 1'b0, 0);
        table_vecs[1] = mk(1'b0, 1'b1, 10, 0, 1'b0, 0);
        table_vecs[2] = mk(1'b0, 1'b1, 11, 0, 1'b0, 0);
        table_vecs[3] = mk(1'b1, 1'b1, 12, 0, 1'b0, 0);
        table_vecs[4] = mk(1'b1, 1'b0, 13, 6, 1'b0, 0);
        table_vecs[5] = mk(1'b1, 1'b0, 14, 6, 1'b0, 0);
        table_vecs[6] = mk(1'b1, 1'b1, 15, 6, 1'b0, 0);
        table_vecs[7] = mk(1'b1, 1'b1, 0,  7, 1'b0, 0);
        table_vecs[8] = mk(1'b0, 1'b1, 10, 7, 1'b1, 1);
        table_vecs[9] = mk(1'b1, 1'b1, 11, 7, 1'b0, 1);
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(table_vecs[i]);
            checkOutput();
        end

        // Syncs tied high: counters free-run, never lock, never flag.
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            v = mk(1'b1, 1'b1, (i + 1) % T_HTOT, ((i + 1) / T_HTOT) % T_VTOT, 1'b0, 0);
            applyStimulus(v);
            checkOutput();
        end

        // Clean generator from reset: lock after the third vfall, then track 3 frames.
        apply_reset();
        for (int i = 0; i < 816; i++) begin
            gen_step(1'b0, i >= T_HTOT * VS_LINE);
        end

        // One line with hsync stuck high while locked.
        while (!((gx == 0) && (gy == 1))) gen_step(1'b0, 1'b1);
        for (int i = 0; i < T_HTOT; i++) begin
            gen_vec(v, gx == HS_FALL, 1'b1);
            v.hsync = 1'b1;
            run_sample(v);
        end
        for (int i = 0; i < 3 * FRAME; i++) gen_step(1'b0, 1'b1);
        check_val("relock_after_line_loss", int'(bus.locked), 1);
        check_val("err_count_after_line_loss", int'(bus.err_count), 1);

        // hfall injected 10 cycles early while locked.
        while (!((gx == 0) && (gy == 2))) gen_step(1'b0, 1'b1);
        gen_vec(v, 1'b1, 1'b1);
        v.hsync = 1'b0;
        v.x     = 12'(HS_FALL);
        v.de    = 1'b0;
        run_sample(v);
        while (!((gx == 0) && (gy == VS_LINE))) gen_step(1'b0, 1'b0);
        for (int i = 0; i < 3 * FRAME; i++) gen_step(1'b0, 1'b1);
        check_val("relock_after_early_hfall", int'(bus.locked), 1);
        check_val("err_count_after_early_hfall", int'(bus.err_count), 2);

        // Single-cycle rst mid-frame while locked.
        while (!((gx == 5) && (gy == 3))) gen_step(1'b0, 1'b1);
        v = mk(gen_hs(), gen_vs(), 0, 0, 1'b0, 0);
        rst = 1'b1;
        run_sample(v);
        rst     = 1'b0;
        lk      = 1'b0;
        vf_left = T_LOCK + 1;
        exp_err = 0;
        while (!((gx == 0) && (gy == VS_LINE))) gen_step(1'b0, 1'b0);
        for (int i = 0; i < 3 * FRAME; i++) gen_step(1'b0, 1'b1);
        check_val("relock_after_rst", int'(bus.locked), 1);

        // Generator one line too tall: error every frame, counter saturates.
        gen_vt = T_VT + 1;
        apply_reset();
        while (gen_frame < 258) begin
            gen_step((gx == 0) && (gy == VS_LINE - 1) && (gen_frame >= 1), 1'b0);
        end
        check_val("err_count_saturated", int'(bus.err_count), 255);
        check_val("never_locked_tall_frame", int'(bus.locked), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the 640x480 VGA timing generator.
- Takes the active-low hsync/vsync pair in the same 25 MHz domain and reconstructs pixel_x, pixel_y and the display-enable window.
- Checks the line and frame timing continuously and reports lock and timing errors.
- Used for loopback checking of the video path and by downstream pixel consumers that see only sync signals.

Parameters:
- HD, 640, horizontal display width
- HR, 16, right border
- HRET, 96, horizontal retrace (hsync low width)
- HL, 48, left border
- VD, 480, vertical display height
- VB, 10, bottom border
- VRET, 2, vertical retrace (vsync low width)
- VT, 33, top border
- LOCK_FRAMES, 2, consecutive clean frames needed to declare lock
- Derived: HTOT = 800, VTOT = 525

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous reset, active-high
- hsync  in  1  horizontal sync, active-low, synchronous to clk
- vsync  in  1  vertical sync, active-low, synchronous to clk
- pixel_x  out  12  reconstructed column, 0..799
- pixel_y  out  12  reconstructed row, 0..524
- de  out  1  display enable
- locked  out  1  timing locked
- frame_start  out  1  one-cycle pulse at (0,0) while locked
- sync_err  out  1  one-cycle pulse on any timing violation while not in SEARCH
- err_count  out  8  saturating count of sync_err pulses; cleared only by rst

Behaviour:
- Reset values:
  - x = y = 0; pixel_x = pixel_y = 0
  - de = locked = frame_start = sync_err = 0; err_count = 0
  - hs_prev = vs_prev = 1, so no spurious edge after reset
  - state = SEARCH; h_seen = 0; good = 0
- Edge detection:
  - hfall = !hsync & hs_prev; hrise = hsync & !hs_prev
  - vfall = !vsync & vs_prev
  - hs_prev and vs_prev are updated every cycle.
- Internal counters x and y describe the current input sample; they use the generator convention (hsync low for x = 656..751, vsync falls at x = 0, y = 490).
  - x: if hfall, x = HD+HR (656); else x wraps 799 -> 0, otherwise increments.
  - y: if vfall, y = VD+VB (490); else on the x wrap 799 -> 0, y wraps 524 -> 0, otherwise increments.
  - hfall takes priority over normal increment; vfall takes priority over line increment.
- Outputs are registered one cycle after the input sample:
  - pixel_x = x, pixel_y = y.
  - de = locked & (x < 640) & (y < 480), using the pre-update locked value.
  - frame_start = locked & x == 0 & y == 0.
- Latency: 1 clk. When driven directly by the generator and locked, pixel_x(t+1) == generator pixel_x(t); the same holds for y and for de versus video_on.
- Violations, checked only when state != SEARCH:
  - hfall while the free-running prediction != 656
  - prediction == 656 with no hfall (missing edge)
  - hrise while the prediction != 752
  - vfall while the prediction is not (x = 0, y = 490)
  - prediction == (0, 490) with no vfall
  - Any violation pulses sync_err for 1 cycle and increments err_count (saturates at 255).
  - Counters still realign to the received edge.
- State machine:
  - SEARCH: hfall sets h_seen. On vfall with h_seen = 1 (including hfall and vfall in the same cycle): good = 0, go to VERIFY.
  - VERIFY: violation -> SEARCH with h_seen = 0. Clean vfall -> good + 1; when good reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: locked = 1. Violation -> SEARCH; locked and de drop on the next output cycle.
  - Simultaneous violation and clean vfall: the violation wins.
- Inputs held constant (sync lost) are detected through the missing-edge rules, which force SEARCH within one line.
- rst asserted mid-frame restores all reset values on the next edge; relock requires a full SEARCH sequence.

Test Plan:
- Generator and decoder both reset, generator hsync/vsync fed directly:
  - first vfall at input cycle 392000;
  - locked rises on the output cycle after input cycle 1232000;
  - after lock, pixel_x/pixel_y/de equal the generator outputs delayed 1 clk for 3 frames, with err_count = 0.
- While locked, force hsync high for one full line → sync_err pulses at prediction x = 656; locked = 0 the next cycle; err_count = 1; relock after 2 further clean frames.
- While locked, inject an hfall 10 cycles early → sync_err, counters realign (pixel_x reads 656 one cycle after the injected edge), state returns to SEARCH.
- Generator running with VT = 34 (526 lines) → the decoder never asserts locked; sync_err pulses once per frame in VERIFY; err_count saturates at 255 after 255 errors.
- rst asserted for 1 cycle mid-frame while locked → all outputs 0 on the next cycle, no sync_err in SEARCH, lock reacquired about 1.2M cycles later.
- hsync and vsync tied high from reset → state stays SEARCH, locked = 0, sync_err never pulses.
